clock_period_meter: RTL and testbench

Measures the half-period of a slow square wave (such as the output of the generic clock divider, or a board button/LED strobe) in cycles of the fast board clock. It is the receiving end of the divided-clock path: the divider turns `clk_in` cycles into toggles, and this block turns toggles back into a cycle count. Its output is a registered count with a one-cycle valid strobe, used for self-check of divider settings and for game-speed calibration logic.

---
 rtl/clock_meter_pkg.sv | 13 +
 rtl/clock_period_meter_sync_edge_detect.sv | 34 +++
 rtl/clock_period_meter.sv | 120 ++++++++++++
 tb/tb_clock_period_meter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_meter_pkg.sv
// Shared encodings and defaults for the clock period meter and divider tests.
// Holds the FSM states and the default WIDTH / SYNC_STAGES.
package clock_meter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_e;

  localparam int DEFAULT_WIDTH       = 16;
  localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/clock_period_meter_sync_edge_detect.sv
// Synchronizer chain for an asynchronous input plus previous-level register.
// Emits the synced level and a one-cycle pulse on either edge.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic sig_in,
  output logic level,
  output logic edge_p
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], sig_in};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level  = sync_q[STAGES-1];
  assign edge_p = sync_q[STAGES-1] ^ prev_q;

endmodule

// File: rtl/clock_period_meter.sv
// Half-period meter: counts clk_in cycles between edges of sig_in.
// Optional stall timeout enabled with PERIOD_METER_TIMEOUT_EN.
module clock_period_meter
  import clock_meter_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic             level_out,
  output logic [WIDTH-1:0] period_out,
  output logic             period_ovf,
  output logic             period_valid,
  output logic             stalled
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic edge_p;

  meter_state_e     state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
`ifdef PERIOD_METER_TIMEOUT_EN
  logic             stalled_q, stalled_d;
`endif

  sync_edge_detect #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .sig_in (sig_in),
    .level  (level_out),
    .edge_p (edge_p)
  );

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;
`ifdef PERIOD_METER_TIMEOUT_EN
    stalled_d = stalled_q;
`endif
    if (edge_p)
      cnt_d = ONE;
    else if (cnt_q == MAX)
      cnt_d = MAX;
    else
      cnt_d = cnt_q + ONE;

    unique case (state_q)
      IDLE: begin
        // first edge after reset or timeout only arms
        if (edge_p) begin
          state_d   = MEASURE;
`ifdef PERIOD_METER_TIMEOUT_EN
          stalled_d = 1'b0;
`endif
        end
      end
      MEASURE: begin
        if (edge_p) begin
          period_d = cnt_q;
          valid_d  = 1'b1;
`ifdef PERIOD_METER_TIMEOUT_EN
          ovf_d    = 1'b0;
`else
          ovf_d    = (cnt_q == MAX);
`endif
        end
`ifdef PERIOD_METER_TIMEOUT_EN
        else if (cnt_q == MAX) begin
          stalled_d = 1'b1;
          state_d   = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
`ifdef PERIOD_METER_TIMEOUT_EN
      stalled_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
`ifdef PERIOD_METER_TIMEOUT_EN
      stalled_q <= stalled_d;
`endif
    end
  end

  assign period_out   = period_q;
  assign period_ovf   = ovf_q;
  assign period_valid = valid_q;
`ifdef PERIOD_METER_TIMEOUT_EN
  assign stalled      = stalled_q;
`else
  assign stalled      = 1'b0;
`endif

endmodule

// File: tb/tb_clock_period_meter.sv
// Scoreboard bench for clock_period_meter with a cycle-stamped edge model.
// Honours PERIOD_METER_TIMEOUT_EN when the build defines it.
module tb_clock_period_meter;

  localparam int W   = 8;
  localparam int MAX = (1 << W) - 1;
  localparam int LAT = 3;
  localparam int INF = 32'h7fffffff;

  typedef struct {
    int       cyc;
    int       p;
    bit       ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sig_in = 1'b0;
  logic         level_out;
  logic [W-1:0] period_out;
  logic         period_ovf;
  logic         period_valid;
  logic         stalled;

  clock_period_meter #(
    .WIDTH       (W),
    .SYNC_STAGES (2)
  ) dut (
    .clk_in       (clk),
    .rst          (rst),
    .sig_in       (sig_in),
    .level_out    (level_out),
    .period_out   (period_out),
    .period_ovf   (period_ovf),
    .period_valid (period_valid),
    .stalled      (stalled)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   started = 0;
  exp_t q[$];
  bit   hist [0:65535];
  int   rel = 0;
  bit   armed = 0;
  int   last = 0;
  int   st_pf = INF;
  int   st_pt = INF;
  int   st_cf = INF;
  int   exp_po = 0;
  bit   exp_ov = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  // model: one interval per pair of sig_in transitions, in drive cycles
  task automatic note_edge(input int c);
    int d;
    exp_t e;
    if (!armed) begin
      armed = 1;
      last  = c;
`ifdef PERIOD_METER_TIMEOUT_EN
      st_cf = c + LAT + MAX;
`endif
      return;
    end
    d    = c - last;
    last = c;
    e.cyc = c + LAT;
`ifdef PERIOD_METER_TIMEOUT_EN
    if (d > MAX) begin
      st_pf = st_cf;
      st_pt = c + LAT;
      st_cf = c + LAT + MAX;
      return;
    end
    st_cf = c + LAT + MAX;
    e.p   = d;
    e.ovf = 0;
`else
    e.p   = (d >= MAX) ? MAX : d;
    e.ovf = (d >= MAX);
`endif
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v);
    if (v !== sig_in) note_edge(cyc);
    sig_in = v;
  endtask

  task automatic phase(input int d);
    wait_cyc(d);
    drive(~sig_in);
  endtask

  task automatic do_reset();
    exp_t dummy;
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    while (q.size() > 0 && q[q.size()-1].cyc >= cyc)
      dummy = q.pop_back();
    armed = 0;
    rel   = cyc;
    st_pf = st_cf;
    st_pt = cyc;
    st_cf = INF;
    started = 1;
    if (sig_in) note_edge(cyc);
  endtask

  always @(negedge clk) begin
    if (started) begin
      exp_t e;
      bit   exp_v;
      bit   exp_lv;
      bit   exp_st;
      hist[cyc % 65536] = sig_in;
      exp_v = 0;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk("missing_valid", 0, 1);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e      = q.pop_front();
        exp_v  = 1;
        exp_po = e.p;
        exp_ov = e.ovf;
      end
      exp_lv = (cyc - 2 >= rel) ? hist[(cyc - 2) % 65536] : 1'b0;
      exp_st = (cyc >= st_pf && cyc < st_pt) || (cyc >= st_cf);
      chk("period_valid", int'(period_valid), int'(exp_v));
      chk("period_out", int'(period_out), exp_po);
      chk("period_ovf", int'(period_ovf), int'(exp_ov));
      chk("level_out", int'(level_out), int'(exp_lv));
      chk("stalled", int'(stalled), int'(exp_st));
      if (rst) begin
        exp_po = 0;
        exp_ov = 0;
      end
    end
  end

  initial begin
    wait_cyc(3);
    do_reset();
    wait_cyc(4);
    // divider with DIVISOR = 5
    repeat (10) phase(5);
    // asymmetric square wave
    repeat (4) begin
      phase(37);
      phase(12);
    end
    // toggle every cycle
    repeat (12) phase(1);
    // saturation boundaries
    phase(300);
    phase(MAX);
    phase(MAX + 1);
    phase(MAX - 1);
    phase(3);
    phase(4);
    // reset mid-measurement
    phase(10);
    wait_cyc(6);
    do_reset();
    phase(7);
    phase(9);
    phase(6);
    // sig_in high across reset release
    if (!sig_in) phase(5);
    wait_cyc(6);
    do_reset();
    phase(11);
    phase(4);
    phase(8);
    // randomized intervals
    repeat (150) begin
      if ($urandom_range(0, 19) == 0)
        phase($urandom_range(MAX - 5, MAX + 15));
      else
        phase($urandom_range(1, 30));
    end
    wait_cyc(10);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "bench did not complete");
  end

endmodule
